// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter_if
// Description : Bundle of the requester-side handshake and shared register
//               signals of dff_bank_arbiter.
//               master : requester side (drives req/wdata)
//               slave  : arbiter side (drives gnt/ack/owner/q)
// Signals     : req   [N_REQ]        per-requester write request, level
//               wdata [N_REQ*WIDTH]  requester i data on [i*WIDTH +: WIDTH]
//               gnt   [N_REQ]        one-hot grant
//               ack                  write-commit pulse
//               owner [clog2(N_REQ)] current or last grantee index
//               q     [WIDTH]        shared register contents
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   ack;
    logic [OW-1:0]          owner;
    logic [WIDTH-1:0]       q;

    modport master (
        output req,
        output wdata,
        input  gnt,
        input  ack,
        input  owner,
        input  q
    );

    modport slave (
        input  req,
        input  wdata,
        output gnt,
        output ack,
        output owner,
        output q
    );
endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin arbiter and write sequencer for a shared WIDTH-bit
//               register. One requester is granted at a time; its data is
//               committed one cycle after the grant and priority rotates to
//               the requester just above the one that wrote.
// Ports       : clk        rising-edge clock
//               rst        asynchronous, active-high reset
//               bus        dff_bank_arbiter_if.slave (req/wdata in,
//                          gnt/ack/owner/q out)
//               wr_cnt     [16] committed-write counter, wraps
//                          (only with DFF_ARB_STATS_EN)
//               abort_cnt  [8]  abort counter, saturates
//                          (only with DFF_ARB_STATS_EN)
// Options     : `define DFF_ARB_STATS_EN to build the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    dff_bank_arbiter_if.slave       bus
`ifdef DFF_ARB_STATS_EN
    ,
    output logic [15:0]             wr_cnt,
    output logic [7:0]              abort_cnt
`endif
);

    localparam int IDXW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [IDXW-1:0] C_LAST = IDXW'(N_REQ - 1);

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_owner;
    logic [N_REQ-1:0] r_gnt;
    logic             r_ack;
    logic [WIDTH-1:0] r_q;

    logic             w_found;
    logic [IDXW-1:0]  w_sel;
    logic [N_REQ-1:0] w_sel_oh;
    logic [WIDTH-1:0] w_wsel;
    logic [IDXW-1:0]  w_owner_nxt;
    logic             w_owner_req;
    logic             w_commit;
    logic             w_abort;

    // Scan upward from the priority pointer, wrapping at N_REQ; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!w_found && bus.req[j]) begin
                w_found     = 1'b1;
                w_sel       = IDXW'(j);
                w_sel_oh[j] = 1'b1;
            end
        end
    end

    // Grantee's data slice and its current request level.
    always_comb begin
        w_wsel      = '0;
        w_owner_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDXW'(i) == r_owner) begin
                w_wsel      = bus.wdata[i*WIDTH +: WIDTH];
                w_owner_req = bus.req[i];
            end
        end
    end

    // Priority moves past the writer, not past the old pointer, so a skipped
    // requester below the writer is not jumped over twice.
    assign w_owner_nxt = (r_owner == C_LAST) ? '0 : r_owner + 1'b1;

    assign w_commit = (r_state == S_GRANT) &&  w_owner_req;
    assign w_abort  = (r_state == S_GRANT) && !w_owner_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ack   <= 1'b0;
            r_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_sel_oh;
                        r_owner <= w_sel;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt <= '0;
                    if (w_commit) begin
                        r_q     <= w_wsel;
                        r_ack   <= 1'b1;
                        r_ptr   <= w_owner_nxt;
                        r_state <= S_HOLD;
                    end else begin
                        // Requester withdrew: nothing is written, priority kept.
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.ack   = r_ack;
    assign bus.owner = r_owner;
    assign bus.q     = r_q;

`ifdef DFF_ARB_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [7:0]  r_abort_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt    <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_abort && (r_abort_cnt != 8'hFF)) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end
        end
    end

    assign wr_cnt    = r_wr_cnt;
    assign abort_cnt = r_abort_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_abort;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Scoreboard bench for dff_bank_arbiter. Stimulus pushes the
//               expected grant owner and committed data into queues; a
//               monitor pops and compares whenever gnt or ack is seen.
//               Define DFF_ARB_STATS_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

`ifdef DFF_ARB_STATS_EN
    logic [15:0] wr_cnt;
    logic [7:0]  abort_cnt;
`endif

    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef DFF_ARB_STATS_EN
        ,
        .wr_cnt    (wr_cnt),
        .abort_cnt (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int          mptr = 0;
    logic [W-1:0] mq  = '0;
    logic [15:0] mwr  = '0;
    logic [7:0]  mab  = '0;

    int          gq[$];
    int          wq_o[$];
    logic [W-1:0] wq_d[$];
    int          last_gnt_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // Monitor: compares on every falling edge, away from the active edge.
    logic [N-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_gnt = '0;
        end else begin
            logic [N-1:0] eg;
            int e;
            chk("q_vs_model", {24'd0, bus.q}, {24'd0, mq});
            if (bus.gnt != '0 || bus.ack) begin
                chk("gnt_ack_exclusive", {31'd0, (bus.gnt != '0) && bus.ack}, 32'd0);
            end
            if (bus.gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {28'd0, bus.gnt}, 32'd0);
                end else begin
                    e  = gq.pop_front();
                    eg = '0;
                    eg[e] = 1'b1;
                    chk("gnt_onehot", {28'd0, bus.gnt}, {28'd0, eg});
                    chk("gnt_owner", {30'd0, bus.owner}, e);
                end
            end
            if (bus.ack) begin
                if (wq_o.size() == 0) begin
                    chk("ack_unexpected", {31'd0, bus.ack}, 32'd0);
                end else begin
                    logic [W-1:0] d;
                    e  = wq_o.pop_front();
                    d  = wq_d.pop_front();
                    eg = '0;
                    eg[e] = 1'b1;
                    chk("ack_data", {24'd0, bus.q}, {24'd0, d});
                    chk("ack_owner", {30'd0, bus.owner}, e);
                    chk("ack_after_gnt", {28'd0, prev_gnt}, {28'd0, eg});
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic chk_stats();
`ifdef DFF_ARB_STATS_EN
        chk("wr_cnt", {16'd0, wr_cnt}, {16'd0, mwr});
        chk("abort_cnt", {24'd0, abort_cnt}, {24'd0, mab});
`endif
    endtask

    // One arbitration: drive mask, wait for grant, then commit or abort.
    // Returns one cycle after the DUT is back in (or about to enter) IDLE.
    task automatic run_round(input logic [N-1:0] mask, input logic [N*W-1:0] data, input bit abort);
        int   w;
        bit   seen;
        logic [N-1:0] wbit;
        bus.req   = mask;
        bus.wdata = data;
        w = pick(mask);
        gq.push_back(w);
        wbit = '0;
        wbit[w] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(posedge clk);
            #1;
            if (bus.gnt != '0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got gnt=%0h expected a grant to %0d", bus.gnt, w);
            bus.req = '0;
            gq.delete();
            return;
        end
        last_gnt_cyc = cyc;
        if (abort) begin
            bus.req = '0;
            if (mab != 8'hFF) mab = mab + 8'd1;
            @(posedge clk);
            #1;
        end else begin
            wq_o.push_back(w);
            wq_d.push_back(data[w*W +: W]);
            @(posedge clk);
            #1;
            mq   = data[w*W +: W];
            mptr = (w + 1) % N;
            mwr  = mwr + 16'd1;
            bus.req   = mask & ~wbit;
            bus.wdata = $urandom;
            @(posedge clk);
            #1;
            bus.req = '0;
        end
    endtask

    initial begin
        int prev_c;
        bus.req   = '0;
        bus.wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_owner", {30'd0, bus.owner}, 32'd0);
        chk("rst_q", {24'd0, bus.q}, 32'd0);
        chk_stats();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load q=0x5A, then reset asynchronously during the next GRANT
        run_round(4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00}, 1'b0);
        chk("pre_rst_q", {24'd0, bus.q}, 32'h5A);
        bus.req   = 4'b0100;
        bus.wdata = {8'h00, 8'h77, 8'h00, 8'h00};
        @(posedge clk);
        #1;
        chk("pre_rst_gnt", {28'd0, bus.gnt}, 32'b0100);
        rst  = 1'b1;
        mq   = '0;
        mptr = 0;
        mwr  = '0;
        mab  = '0;
        #1;
        chk("async_rst_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("async_rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("async_rst_owner", {30'd0, bus.owner}, 32'd0);
        chk("async_rst_q", {24'd0, bus.q}, 32'd0);
        chk_stats();
        bus.req = '0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First request after reset goes to index 0
        run_round(4'b0001, {8'h00, 8'h00, 8'h00, 8'h3C}, 1'b0);
        chk("post_rst_owner", {30'd0, bus.owner}, 32'd0);
        run_round(4'b1000, {8'hC3, 8'h00, 8'h00, 8'h00}, 1'b0);

        // Fairness: all request, each winner re-raises after its ack
        prev_c = 0;
        for (int i = 0; i < 5; i++) begin
            run_round(4'b1111, {$urandom}, 1'b0);
            if (i > 0) chk("rr_gap", last_gnt_cyc - prev_c, 32'd3);
            prev_c = last_gnt_cyc;
            chk("rr_order", {30'd0, bus.owner}, i % N);
        end
        chk_stats();

        // Single write to requester 2
        run_round(4'b0100, {8'h11, 8'hA5, 8'h22, 8'h33}, 1'b0);
        chk("single_owner", {30'd0, bus.owner}, 32'd2);
        chk("single_q", {24'd0, bus.q}, 32'hA5);

        // Wrap and skip: ptr is 3, only requester 1 asks
        run_round(4'b0010, {$urandom}, 1'b0);
        chk("wrap_owner", {30'd0, bus.owner}, 32'd1);
        run_round(4'b1111, {$urandom}, 1'b0);
        chk("wrap_ptr_next", {30'd0, bus.owner}, 32'd2);

        // Abort: grant then withdraw
        run_round(4'b0001, {$urandom}, 1'b1);
        chk("abort_q_kept", {24'd0, bus.q}, {24'd0, mq});
        chk_stats();
        run_round(4'b1111, {$urandom}, 1'b0);
        chk("abort_ptr_kept", {30'd0, bus.owner}, 32'd3);

`ifdef DFF_ARB_STATS_EN
        force dut.r_wr_cnt = 16'hFFFF;
        #1;
        release dut.r_wr_cnt;
        mwr = 16'hFFFF;
        run_round(4'b0100, {$urandom}, 1'b0);
        chk_stats();
`endif

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            run_round(m, {$urandom}, ($urandom_range(0, 3) == 0));
        end
        chk_stats();

        repeat (3) @(posedge clk);
        #1;
        chk("gq_drained", gq.size(), 32'd0);
        chk("wq_drained", wq_o.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit storage register built from async-reset D flip-flops. Up to N_REQ requesters compete for write access through a req/gnt/ack handshake. The arbiter grants one requester at a time, commits the granted requester's data into the register, and rotates priority so no requester starves. It sits between requester blocks and the shared register, and is the only writer of that register.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, stored data width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; clock clk
- req  in  N_REQ  per-requester write request, level
- wdata  in  N_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, registered
- ack  out  1  write-commit pulse, registered
- owner  out  $clog2(N_REQ)  index of current or last grantee
- q  out  WIDTH  shared register contents

## Operation
- Reset values: gnt=0, ack=0, owner=0, q=0, priority pointer ptr=0, state IDLE.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning upward from ptr and wrapping modulo N_REQ.
  - Set gnt to that one-hot bit and owner to its index, then go to GRANT.
- State GRANT:
  - If req[owner]=1: set q<=wdata[owner], ack<=1, gnt<=0, ptr<=(owner+1) mod N_REQ, and go to HOLD.
  - If req[owner]=0 (abort): set gnt<=0, leave q, ack and ptr unchanged, and go to IDLE.
- State HOLD: ack<=0, go to IDLE. The requester must drop req while ack is high.
- Requests arriving or changing during GRANT or HOLD are not considered until the next IDLE evaluation.
- wdata is sampled only on the GRANT-state edge. It is don't-care at all other times.
- The pointer wraps from N_REQ-1 to 0. Pointer advance uses owner+1, not ptr+1.

## Timing
- Clock edges are E0, E1, E2, ... Request seen in IDLE at E0.
- gnt is high from E0 to E1.
- q is updated and ack is high from E1 to E2.
- The next IDLE arbitration happens at E3.
- Minimum 3 cycles per write; maximum throughput is one write per 3 clocks.
- Worst-case wait for a continuously requesting requester is N_REQ*3 cycles plus its own 3 cycles.
- An abort costs 2 cycles: E0 grant, E1 return to IDLE.
- gnt and ack are never high in the same cycle. gnt is always zero or exactly one-hot.
- rst asserted mid-operation (any state) immediately clears every output and ptr, with no clock needed.
- Any in-flight write is lost if rst is asserted at or before its GRANT edge.

## Configuration
- DFF_ARB_STATS_EN defined:
  - Adds output wr_cnt (16 bits, reset 0), which increments by 1 on every committed write (the GRANT-to-HOLD transition) and wraps 0xFFFF to 0.
  - Adds output abort_cnt (8 bits, reset 0), which increments on every abort and saturates at 0xFF.
- DFF_ARB_STATS_EN undefined: neither port exists and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset: drive rst=1 mid-GRANT with q=0x5A.
  - Required: gnt=0, ack=0, q=0x00, owner=0 asynchronously.
  - After release, first request from req=0b0001 is granted to index 0.
- Single write: req=0b0100, wdata[2]=0xA5.
  - Required: gnt=0b0100 for 1 cycle, then q=0xA5 and ack=1 for 1 cycle, owner=2.
- Round-robin fairness: req=0b1111 held, with each requester re-raising after its ack.
  - Required: grant order 0,1,2,3,0, each 3 cycles apart.
  - Required: q matches each grantee's wdata.
- Wrap and skip: ptr=3, req=0b0010.
  - Required: grant to index 1, ptr becomes 2.
- Abort: req=0b0001 for 1 cycle only, then 0.
  - Required: gnt pulse for 1 cycle, no ack, q unchanged, ptr unchanged.
  - Required with DFF_ARB_STATS_EN: abort_cnt=1, wr_cnt=0.
- Stats wrap (DFF_ARB_STATS_EN): force wr_cnt to 0xFFFF, then perform one write.
  - Required: wr_cnt=0x0000, abort_cnt unchanged.
